// File: rtl/pic_ram_arbiter.sv
// pic_ram_arbiter: shares one single-port pixel RAM between a priority display read pipe and a FIFO-buffered loader write path
module pic_ram_arbiter #(
  parameter int DEPTH = 4800,
  parameter int AW = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic [1:0]    gnt,
  output logic          err_addr,
  input  logic          err_clr,
  output logic [AW-1:0] wr_cnt
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FD = (PW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] LIM = AW'(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, READ = 2'b01, WRITE = 2'b10} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_fa [FIFO_DEPTH];
  logic [7:0] r_fd [FIFO_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0] r_count, w_count_nx;
  logic w_push, w_keep, w_pop, w_oor, r_rd_p2;
  always_comb begin
    w_oor = wr_addr >= LIM;
    w_push = wr_valid & wr_ready;
    w_keep = w_push & ~w_oor;
    w_next = rd_req ? READ : (r_count != '0 ? WRITE : IDLE);
    w_pop = w_next == WRITE;
    w_count_nx = r_count + (PW + 1)'(w_keep) - (PW + 1)'(w_pop);
  end
  assign gnt = r_state;
  always_ff @(posedge clk) begin
    if (w_keep) begin
      r_fa[r_tail] <= wr_addr;
      r_fd[r_tail] <= wr_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      wr_ready <= 1'b0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
      wr_cnt <= '0;
      err_addr <= 1'b0;
      r_rd_p2 <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_nx;
      wr_ready <= w_count_nx < FD;
      ram_we <= w_pop;
      if (w_next == READ) ram_addr <= rd_addr;
      else if (w_pop) ram_addr <= r_fa[r_head];
      if (w_pop) begin
        ram_wdata <= r_fd[r_head];
        r_head <= r_head + PW'(1);
        wr_cnt <= wr_cnt + AW'(1);
      end
      if (w_keep) r_tail <= r_tail + PW'(1);
      err_addr <= (w_push & w_oor) | (err_addr & ~err_clr);
      r_rd_p2 <= r_state == READ;
      rd_valid <= r_rd_p2;
      if (r_rd_p2) rd_data <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_pic_ram_arbiter.sv
// tb_pic_ram_arbiter: directed and randomized checks of pic_ram_arbiter against a queue-based transaction model
module tb_pic_ram_arbiter;
  localparam logic [12:0] LIM = 13'd4800;
  logic clk = 0, rst = 1, rd_req = 0, wr_valid = 0, err_clr = 0;
  logic [12:0] rd_addr = 0, wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data, ram_wdata, ram_rdata;
  logic rd_valid, wr_ready, ram_we, err_addr;
  logic [12:0] ram_addr, wr_cnt;
  logic [1:0] gnt;
  logic [7:0] mem [0:8191];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  pic_ram_arbiter dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .gnt(gnt), .err_addr(err_addr), .err_clr(err_clr), .wr_cnt(wr_cnt)
  );
  typedef struct {logic [12:0] a; logic [7:0] d;} wr_t;
  typedef struct {int due; logic [7:0] d; bit k;} rd_t;
  wr_t q[$];
  rd_t rq[$];
  logic [7:0] shadow [0:8191];
  bit known [0:8191];
  logic [7:0] img [0:4799];
  bit m_ready, m_err, m_we;
  logic [1:0] m_gnt;
  logic [12:0] m_ram_addr;
  logic [7:0] m_wdata;
  int m_cnt, cyc, tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    rq.delete();
    m_ready = 0;
    m_err = 0;
    m_we = 0;
    m_gnt = 0;
    m_ram_addr = 0;
    m_wdata = 0;
    m_cnt = 0;
  endtask
  task automatic check_out();
    bit ev;
    rd_t r;
    ev = rq.size() > 0 && rq[0].due == cyc;
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) begin
      r = rq.pop_front();
      if (r.k) chk("rd_data", 32'(rd_data), 32'(r.d));
    end
    if (rst) begin
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
    end
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("ram_we", 32'(ram_we), 32'(m_we));
    chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    chk("wr_cnt", 32'(wr_cnt), 32'(m_cnt));
    chk("err_addr", 32'(err_addr), 32'(m_err));
    chk("wr_ready", 32'(wr_ready), 32'(m_ready));
    if (m_gnt != 2'b00) chk("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
  endtask
  task automatic step();
    bit acc;
    wr_t e;
    rd_t r;
    acc = wr_valid && m_ready && !rst;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else begin
      m_we = 0;
      if (rd_req) begin
        m_gnt = 2'b01;
        m_ram_addr = rd_addr;
        r.due = cyc + 2;
        r.d = shadow[rd_addr];
        r.k = known[rd_addr];
        rq.push_back(r);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_gnt = 2'b10;
        m_we = 1;
        m_ram_addr = e.a;
        m_wdata = e.d;
        shadow[e.a] = e.d;
        known[e.a] = 1;
        m_cnt = (m_cnt + 1) % 8192;
      end else m_gnt = 2'b00;
      if (acc && wr_addr < LIM) begin
        e.a = wr_addr;
        e.d = wr_data;
        q.push_back(e);
      end
      if (acc && wr_addr >= LIM) m_err = 1;
      else if (err_clr) m_err = 0;
      m_ready = q.size() < 4;
    end
    #1;
    check_out();
  endtask
  task automatic do_reset(input int n);
    rst = 1;
    model_reset();
    #1;
    check_out();
    repeat (n) step();
    rst = 0;
  endtask
  initial begin
    int k, idx, bound, bad;
    bit acc;
    cyc = 0;
    for (int i = 0; i < 8192; i++) known[i] = 0;
    for (int i = 0; i < 4800; i++) img[i] = 8'($urandom);
    model_reset();
    repeat (3) step();
    rst = 0;
    step();
    chk("ready_rise", 32'(wr_ready), 1);
    wr_valid = 1; wr_addr = 100; wr_data = 8'hE0;
    step();
    wr_valid = 0;
    repeat (2) step();
    rd_req = 1; rd_addr = 100;
    step();
    chk("lat_gnt", 32'(gnt), 1);
    chk("lat_addr", 32'(ram_addr), 100);
    rd_req = 0;
    step();
    chk("lat_n2_valid", 32'(rd_valid), 0);
    step();
    chk("lat_valid", 32'(rd_valid), 1);
    chk("lat_data", 32'(rd_data), 32'h0E0);
    do_reset(2);
    step();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      rd_req = 1; rd_addr = 13'($urandom_range(0, 4799));
      wr_valid = k < 4; wr_addr = 13'(k); wr_data = 8'(8'h11 + k);
      acc = wr_valid && m_ready;
      step();
      chk("prio_no_we", 32'(ram_we), 0);
      if (acc) begin
        k++;
        if (k == 4) chk("prio_full_ready", 32'(wr_ready), 0);
      end
    end
    rd_req = 0; wr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("prio_gnt", 32'(gnt), 2);
      chk("prio_addr", 32'(ram_addr), 32'(i));
      chk("prio_data", 32'(ram_wdata), 32'(8'h11 + i));
    end
    chk("prio_cnt", 32'(wr_cnt), 4);
    k = 0;
    rd_req = 1; wr_valid = 1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = 13'(10 + k); wr_data = 8'($urandom);
      acc = m_ready;
      step();
      if (acc) k++;
    end
    chk("full_ready", 32'(wr_ready), 0);
    rd_req = 0;
    step();
    chk("full_pop_gnt", 32'(gnt), 2);
    chk("full_ready_rise", 32'(wr_ready), 1);
    rd_req = 1; wr_addr = 13'(20);
    step();
    chk("full_refill", 32'(wr_ready), 0);
    rd_req = 0; wr_valid = 0;
    repeat (6) step();
    chk("full_cnt", 32'(wr_cnt), 9);
    wr_valid = 1; wr_addr = 13'd4800; wr_data = 8'h5A;
    step();
    wr_valid = 0;
    repeat (3) step();
    chk("oor_err", 32'(err_addr), 1);
    chk("oor_cnt", 32'(wr_cnt), 9);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("oor_clr", 32'(err_addr), 0);
    wr_valid = 1; wr_addr = 13'd8191; err_clr = 1;
    step();
    wr_valid = 0; err_clr = 0;
    chk("oor_set_wins", 32'(err_addr), 1);
    err_clr = 1;
    step();
    err_clr = 0;
    rd_req = 1; rd_addr = 7; wr_valid = 1; wr_addr = 300; wr_data = 8'hA5;
    step();
    wr_addr = 301; wr_data = 8'h5A;
    step();
    wr_valid = 0;
    step();
    rd_req = 0;
    do_reset(2);
    repeat (6) step();
    chk("rst_mid_cnt", 32'(wr_cnt), 0);
    for (int i = 0; i < 2000; i++) begin
      rd_req = $urandom_range(0, 1) == 1;
      rd_addr = 13'($urandom);
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(4800, 8191)) : 13'($urandom_range(0, 4799));
      wr_data = 8'($urandom);
      err_clr = $urandom_range(0, 9) == 0;
      step();
    end
    rd_req = 0; wr_valid = 0; err_clr = 0;
    do_reset(2);
    idx = 0;
    for (int line = 0; line < 60; line++) begin
      for (int c = 0; c < 180; c++) begin
        rd_req = c < 80;
        rd_addr = 13'(line * 80 + (c % 80));
        wr_valid = idx < 4800;
        wr_addr = 13'(idx);
        wr_data = idx < 4800 ? img[idx] : 8'h00;
        acc = wr_valid && m_ready;
        step();
        if (acc) idx++;
      end
    end
    bound = 0;
    rd_req = 0;
    while ((idx < 4800 || q.size() > 0) && bound < 3000) begin
      wr_valid = idx < 4800;
      wr_addr = 13'(idx);
      wr_data = idx < 4800 ? img[idx] : 8'h00;
      acc = wr_valid && m_ready;
      step();
      if (acc) idx++;
      bound++;
    end
    chk("frame_drain_bound", 32'(bound < 3000), 1);
    wr_valid = 0;
    repeat (4) step();
    chk("frame_wr_cnt", 32'(wr_cnt), 4800);
    bad = 0;
    for (int a = 0; a < 4800; a++) if (mem[a] !== img[a]) bad++;
    chk("frame_image", 32'(bad), 0);
    for (int i = 0; i < 200; i++) begin
      rd_req = 1;
      rd_addr = 13'($urandom_range(0, 4799));
      step();
    end
    rd_req = 0;
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pic_ram_arbiter.md
PIC_RAM_ARBITER -- requirements
Module: pic_ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 4800, number of valid pixel words (80x60, RGB332)
- AW, 13, address width
- FIFO_DEPTH, 4, write-buffer entries (power of two)

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  display read request; one request per cycle allowed
- rd_addr  in  AW  display read address
- rd_data  out  8  read pixel, registered
- rd_valid  out  1  rd_data valid strobe, one cycle
- wr_valid  in  1  loader write offer
- wr_ready  out  1  write buffer can accept
- wr_addr  in  AW  loader write address
- wr_data  in  8  loader write pixel
- ram_addr  out  AW  single-port RAM address, registered
- ram_we  out  1  RAM write enable, registered
- ram_wdata  out  8  RAM write data, registered
- ram_rdata  in  8  RAM read data, valid one cycle after ram_addr
- gnt  out  2  current RAM owner: 00 idle, 01 read, 10 write
- err_addr  out  1  sticky out-of-range write flag
- err_clr  in  1  clears err_addr
- wr_cnt  out  AW  count of writes committed to RAM, wraps at 2^AW

Function
REQ-003 The block SHALL share one single-port RAM between the display read path and the loader write path; only one RAM access per cycle.
REQ-004 Display reads SHALL have absolute priority: when rd_req=1, the read is issued on the next edge, regardless of buffered writes.
REQ-005 Read latency SHALL be fixed at 3 cycles: rd_req at cycle N -> ram_addr=rd_addr, ram_we=0 at N+1 -> ram_rdata sampled at N+2 -> rd_data, rd_valid=1 at N+3.
REQ-006 Back-to-back rd_req SHALL be fully pipelined: one rd_valid per rd_req, in order, no bubbles.
REQ-007 Write handshake: a write is accepted when wr_valid=1 and wr_ready=1 at the same edge; wr_addr/wr_data are pushed into the FIFO.
REQ-008 wr_ready SHALL equal (FIFO count < FIFO_DEPTH) and rst=0; a pop in the same cycle does not raise wr_ready while full.
REQ-009 Writes with wr_addr >= DEPTH SHALL be accepted but discarded (no RAM write, no wr_cnt change); err_addr SHALL be set on the following edge.
REQ-010 Issue FSM states SHALL be IDLE, READ and WRITE, evaluated every cycle: rd_req=1 -> READ; else FIFO non-empty -> WRITE (pop head, ram_we=1 next edge); else IDLE. gnt SHALL encode the state.
REQ-011 In WRITE, ram_addr/ram_wdata SHALL carry the popped entry for exactly one cycle; wr_cnt SHALL increment on the same edge ram_we is driven high.
REQ-012 In IDLE and READ, ram_we SHALL be 0; ram_wdata holds its last value.
REQ-013 Simultaneous push and pop with the FIFO not full SHALL leave the count unchanged; FIFO order is strict first-in first-out.
REQ-014 err_clr=1 SHALL clear err_addr; if an out-of-range accept occurs in the same cycle, set wins.
REQ-015 A read to an address >= DEPTH SHALL still be issued; rd_data is whatever the RAM returns (no check on the read path).

Reset
REQ-016 While rst=1: rd_data=0, rd_valid=0, wr_ready=0, ram_addr=0, ram_we=0, ram_wdata=0, gnt=00, err_addr=0, wr_cnt=0, FIFO empty, FSM in IDLE.
REQ-017 Reset asserted mid-operation SHALL discard in-flight reads (no rd_valid after release) and all buffered writes.
REQ-018 wr_ready SHALL rise on the first edge after rst deasserts.

Verification
REQ-019 Read latency: rd_req=1, rd_addr=100, RAM[100]=8'hE0 at cycle N -> rd_valid=1, rd_data=8'hE0 at N+3; no write issued.
REQ-020 Priority and starvation: fill FIFO with 4 writes (addr 0..3, data 8'h11..8'h14) while rd_req held high for 10 cycles -> no ram_we during the 10 cycles, wr_ready=0 after the 4th accept, then 4 consecutive WRITE cycles in order, wr_cnt=4.
REQ-021 Full boundary: FIFO full, wr_valid=1 held, one pop occurs -> write accepted only on the edge after wr_ready rises; count never exceeds 4.
REQ-022 Out-of-range: write addr 4800 -> accepted, ram_we never asserted for it, err_addr=1, wr_cnt unchanged; err_clr pulse -> err_addr=0.
REQ-023 Reset mid-flight: rd_req at N, rst at N+1 for 2 cycles, 2 writes buffered -> no rd_valid, no ram_we after release, wr_cnt=0.
REQ-024 Full-frame display stream: 1056x628 timing, 800x600 active, 4800 reads per frame interleaved with 4800 loader writes in blanking -> all reads return on time, final wr_cnt=4800, RAM contents match the loader image.
